merlin_timer_target: RTL and testbench

Memory-mapped machine-timer responder for the Merlin data port. It sits on the target side of the core's data request/response interface, alongside the SRAM and boot ROM, and serves reads and writes to a 64-bit free-running `mtime` counter, a 64-bit `mtimecmp` compare register, a control register and a prescaler. It drives the core's machine timer interrupt input (`irqm_timer_i`), which replaces ad-hoc interrupt generation in system benches.

---
 rtl/merlin_timer_target.sv | 115 +++++++++++
 tb/tb_merlin_timer_target.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merlin_timer_target.sv
// Machine-timer target on the Merlin data port: 64-bit mtime/mtimecmp, ctrl and
// prescaler registers, with a registered level interrupt on mtime >= mtimecmp.
module merlin_timer_target #(
  parameter int C_PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        treqready_o,
  input  logic        treqvalid_i,
  input  logic        treqdvalid_i,
  input  logic [31:0] treqaddr_i,
  input  logic [31:0] treqdata_i,
  input  logic        trspready_i,
  output logic        trspvalid_o,
  output logic [31:0] trspdata_o,
  output logic        irq_o
);

  localparam logic [2:0] SEL_MTIME_LO = 3'd0;
  localparam logic [2:0] SEL_MTIME_HI = 3'd1;
  localparam logic [2:0] SEL_CMP_LO   = 3'd2;
  localparam logic [2:0] SEL_CMP_HI   = 3'd3;
  localparam logic [2:0] SEL_CTRL     = 3'd4;
  localparam logic [2:0] SEL_PRESCALE = 3'd5;

  logic [63:0]             mtime;
  logic [63:0]             mtimecmp;
  logic [63:0]             mtime_inc;
  logic [63:0]             mtime_next;
  logic                    en;
  logic                    ie;
  logic [C_PRESCALE_W-1:0] prescale;
  logic [C_PRESCALE_W-1:0] tick_cnt;
  logic                    accept;
  logic                    wr;
  logic                    rd;
  logic                    tick;
  logic [2:0]              sel;
  logic [31:0]             rdata;
  logic                    unused_addr;

  // Handshake: a request is taken on any edge with treqvalid_i & treqready_o.
  // The response register is a single-entry buffer, so a new request (read or
  // write) may enter only when that buffer is empty or being drained this cycle.
  // trspvalid_o/trspdata_o hold until trspready_i; writes never respond.
  assign treqready_o = ~trspvalid_o | trspready_i;
  assign accept      = treqvalid_i & treqready_o;
  assign wr          = accept & treqdvalid_i;
  assign rd          = accept & ~treqdvalid_i;
  assign sel         = treqaddr_i[4:2];
  assign unused_addr = ^{treqaddr_i[31:5], treqaddr_i[1:0]};

  assign tick      = en & (tick_cnt == prescale);
  assign mtime_inc = mtime + 64'd1;

  // A write to one half wins for that half; the other half keeps the tick result,
  // which drops any carry into a written hi word.
  always_comb begin
    mtime_next = tick ? mtime_inc : mtime;
    if (wr && sel == SEL_MTIME_LO) mtime_next[31:0]  = treqdata_i;
    if (wr && sel == SEL_MTIME_HI) mtime_next[63:32] = treqdata_i;
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_MTIME_LO: rdata = mtime[31:0];
      SEL_MTIME_HI: rdata = mtime[63:32];
      SEL_CMP_LO:   rdata = mtimecmp[31:0];
      SEL_CMP_HI:   rdata = mtimecmp[63:32];
      SEL_CTRL:     rdata = {30'd0, ie, en};
      SEL_PRESCALE: rdata[C_PRESCALE_W-1:0] = prescale;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      en          <= 1'b0;
      ie          <= 1'b0;
      prescale    <= '0;
      tick_cnt    <= '0;
      trspvalid_o <= 1'b0;
      trspdata_o  <= '0;
      irq_o       <= 1'b0;
    end else begin
      mtime <= mtime_next;
      irq_o <= ie & (mtime >= mtimecmp);

      if (wr && (sel == SEL_CTRL || sel == SEL_PRESCALE)) tick_cnt <= '0;
      else if (tick)                                    tick_cnt <= '0;
      else if (en)                                      tick_cnt <= tick_cnt + C_PRESCALE_W'(1);

      if (wr) begin
        case (sel)
          SEL_CMP_LO:   mtimecmp[31:0]  <= treqdata_i;
          SEL_CMP_HI:   mtimecmp[63:32] <= treqdata_i;
          SEL_CTRL:     {ie, en}        <= treqdata_i[1:0];
          SEL_PRESCALE: prescale        <= treqdata_i[C_PRESCALE_W-1:0];
          default:      ;
        endcase
      end

      if (rd) begin
        trspvalid_o <= 1'b1;
        trspdata_o  <= rdata;
      end else if (trspready_i) begin
        trspvalid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_merlin_timer_target.sv
// Bench for merlin_timer_target: register table, hand-written timing corners and
// random traffic, all compared every cycle against a cycle-count reference model.
module tb_merlin_timer_target;

  logic        clk = 1'b0;
  logic        reset;
  logic        treqready_o;
  logic        treqvalid_i;
  logic        treqdvalid_i;
  logic [31:0] treqaddr_i;
  logic [31:0] treqdata_i;
  logic        trspready_i;
  logic        trspvalid_o;
  logic [31:0] trspdata_o;
  logic        irq_o;

  always #5 clk = ~clk;

  merlin_timer_target #(.C_PRESCALE_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .treqready_o  (treqready_o),
    .treqvalid_i  (treqvalid_i),
    .treqdvalid_i (treqdvalid_i),
    .treqaddr_i   (treqaddr_i),
    .treqdata_i   (treqdata_i),
    .trspready_i  (trspready_i),
    .trspvalid_o  (trspvalid_o),
    .trspdata_o   (trspdata_o),
    .irq_o        (irq_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mtime advances on every (prescale+1)-th enabled cycle since
  // the last ctrl/prescale write, counted with plain modulo arithmetic.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic        m_ie;
  logic [15:0] m_pre;
  logic [63:0] m_run;
  logic        m_rspvalid;
  logic [31:0] m_rspdata;
  logic        m_irq;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] s);
    case (s)
      3'd0: return m_mtime[31:0];
      3'd1: return m_mtime[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {30'd0, m_ie, m_en};
      3'd5: return {16'd0, m_pre};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtime    = 64'd0;
    m_cmp      = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en       = 1'b0;
    m_ie       = 1'b0;
    m_pre      = 16'd0;
    m_run      = 64'd0;
    m_rspvalid = 1'b0;
    m_rspdata  = 32'd0;
    m_irq      = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic rr);
    logic        acc;
    logic [2:0]  s;
    logic [31:0] rv;
    logic        irq_n;
    logic [63:0] run_n;
    logic [63:0] nt;
    logic        tick;
    acc   = v && (!m_rspvalid || rr);
    s     = a[4:2];
    rv    = model_read(s);
    irq_n = m_ie && (m_mtime >= m_cmp);
    run_n = m_run;
    tick  = 1'b0;
    if (m_en) begin
      run_n = m_run + 64'd1;
      tick  = (run_n % ({48'd0, m_pre} + 64'd1)) == 64'd0;
    end
    nt = tick ? m_mtime + 64'd1 : m_mtime;
    if (acc && w) begin
      case (s)
        3'd0: nt[31:0]  = d;
        3'd1: nt[63:32] = d;
        3'd2: m_cmp[31:0]  = d;
        3'd3: m_cmp[63:32] = d;
        3'd4: begin m_en = d[0]; m_ie = d[1]; run_n = 64'd0; end
        3'd5: begin m_pre = d[15:0]; run_n = 64'd0; end
        default: ;
      endcase
    end
    m_mtime = nt;
    m_run   = run_n;
    m_irq   = irq_n;
    if (acc && !w) begin
      m_rspvalid = 1'b1;
      m_rspdata  = rv;
    end else if (rr) begin
      m_rspvalid = 1'b0;
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic rr);
    check("trspvalid", trspvalid_o, m_rspvalid);
    if (m_rspvalid) check("trspdata", trspdata_o, m_rspdata);
    check("irq", irq_o, m_irq);
    treqvalid_i  = v;
    treqdvalid_i = w;
    treqaddr_i   = a;
    treqdata_i   = d;
    trspready_i  = rr;
    #1;
    check("treqready", treqready_o, !m_rspvalid || rr);
    model_step(v, w, a, d, rr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic read_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
    cycle(1'b1, 1'b0, a, 32'd0, 1'b1);
    check("read_valid", trspvalid_o, 1'b1);
    check(name, trspdata_o, exp);
  endtask

  initial begin
    int rise_at;
    logic [2:0]  s;
    logic [31:0] a;
    logic [31:0] d;

    vecs[0] = '{32'h0000_0010, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[1] = '{32'h0000_0010, 32'h0000_0002, 32'h0000_0002};
    vecs[2] = '{32'h0000_0014, 32'hFFFF_ABCD, 32'h0000_ABCD};
    vecs[3] = '{32'h0000_0018, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[4] = '{32'h0000_001C, 32'h1234_5678, 32'h0000_0000};
    vecs[5] = '{32'h0000_0008, 32'h1357_9BDF, 32'h1357_9BDF};
    vecs[6] = '{32'h0000_000F, 32'h2468_ACE0, 32'h2468_ACE0};
    vecs[7] = '{32'hFFFF_FF04, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[8] = '{32'h0000_0001, 32'h0000_0055, 32'h0000_0055};
    vecs[9] = '{32'h0000_0010, 32'h0000_0000, 32'h0000_0000};

    // Clock/reset
    reset        = 1'b1;
    treqvalid_i  = 1'b0;
    treqdvalid_i = 1'b0;
    treqaddr_i   = 32'd0;
    treqdata_i   = 32'd0;
    trspready_i  = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_irq", irq_o, 1'b0);
    check("rst_trspvalid", trspvalid_o, 1'b0);
    reset = 1'b0;

    read_expect("rst_mtime_lo", 32'h00, 32'h0000_0000);
    read_expect("rst_cmp_lo", 32'h08, 32'hFFFF_FFFF);
    read_expect("rst_cmp_hi", 32'h0C, 32'hFFFF_FFFF);
    read_expect("rst_ctrl", 32'h10, 32'h0000_0000);
    read_expect("rst_prescale", 32'h14, 32'h0000_0000);

    // Register map table
    for (int i = 0; i < 10; i++) begin
      wr_reg(vecs[i].addr, vecs[i].wdata);
      read_expect("table_read", vecs[i].addr, vecs[i].exp);
    end

    // Prescaled counting
    wr_reg(32'h00, 32'd0);
    wr_reg(32'h04, 32'd0);
    wr_reg(32'h14, 32'd3);
    wr_reg(32'h10, 32'd1);
    idle(40);
    wr_reg(32'h10, 32'd0);
    cycle(1'b1, 1'b0, 32'h00, 32'd0, 1'b1);
    check("presc_model", trspdata_o, m_rspdata);
    check("presc_count", trspdata_o, 32'd10);

    wr_reg(32'h14, 32'd0);
    wr_reg(32'h00, 32'hFFFF_FFFE);
    wr_reg(32'h04, 32'h0000_0000);
    wr_reg(32'h10, 32'd1);
    idle(2);
    wr_reg(32'h10, 32'd0);
    read_expect("carry_lo", 32'h00, 32'd1);
    read_expect("carry_hi", 32'h04, 32'd1);

    // Compare interrupt
    wr_reg(32'h00, 32'd0);
    wr_reg(32'h04, 32'd0);
    wr_reg(32'h0C, 32'd0);
    wr_reg(32'h08, 32'd20);
    wr_reg(32'h10, 32'd3);
    rise_at = -1;
    for (int i = 1; i <= 25; i++) begin
      idle(1);
      if (irq_o && rise_at < 0) rise_at = i;
    end
    check("irq_rise_cycle", rise_at, 21);
    wr_reg(32'h08, 32'd100);
    check("irq_cmp_lag", irq_o, 1'b1);
    idle(1);
    check("irq_cmp_drop", irq_o, 1'b0);
    wr_reg(32'h08, 32'd10);
    idle(1);
    check("irq_again", irq_o, 1'b1);
    wr_reg(32'h10, 32'd1);
    idle(3);
    check("irq_ie_off", irq_o, 1'b0);
    wr_reg(32'h10, 32'd0);

    // Backpressure with a queued write
    wr_reg(32'h14, 32'd7);
    cycle(1'b1, 1'b0, 32'h14, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 32'h08, 32'h0BAD_CAFE, 1'b0);
      check("bp_valid", trspvalid_o, 1'b1);
      check("bp_data", trspdata_o, 32'd7);
      check("bp_ready", treqready_o, 1'b0);
    end
    cycle(1'b1, 1'b1, 32'h08, 32'h0BAD_CAFE, 1'b1);
    read_expect("bp_write", 32'h08, 32'h0BAD_CAFE);

    // Back-to-back write/read
    for (int k = 0; k < 8; k++) begin
      wr_reg(32'h08, 32'hA5A5_0001 + k);
      read_expect("b2b_read", 32'h08, 32'hA5A5_0001 + k);
    end

    // Write/tick collision
    wr_reg(32'h14, 32'd0);
    wr_reg(32'h04, 32'd0);
    wr_reg(32'h10, 32'd1);
    wr_reg(32'h00, 32'h100);
    idle(1);
    read_expect("collide_lo", 32'h00, 32'h101);
    wr_reg(32'h10, 32'd0);

    // Reset with a pending read
    cycle(1'b1, 1'b0, 32'h00, 32'd0, 1'b0);
    check("pend_valid", trspvalid_o, 1'b1);
    treqvalid_i = 1'b0;
    reset       = 1'b1;
    #1;
    check("rst_drop_valid", trspvalid_o, 1'b0);
    check("rst_drop_irq", irq_o, 1'b0);
    model_reset();
    trspready_i = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    read_expect("rst_mid_prescale", 32'h14, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      s = 3'($urandom_range(0, 7));
      a = $urandom();
      a[4:2] = s;
      case (s)
        3'd0: d = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                              : $urandom_range(0, 50);
        3'd1: d = $urandom_range(0, 2);
        3'd2: d = $urandom_range(0, 80);
        3'd3: d = $urandom_range(0, 2);
        3'd5: d = $urandom_range(0, 4);
        default: d = $urandom();
      endcase
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0, a, d,
            $urandom_range(0, 3) != 0);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
